// File: rtl/puf_vote_sequencer_if.sv
// Handshake bundle shared by the key sequencer, the PUF array,
// the majority voter and the key consumer.
interface puf_vote_sequencer_if #(
  parameter int WIDTH = 128
);
  logic             start;
  logic             busy;
  logic             key_valid;
  logic [WIDTH-1:0] key_out;
  logic             key_ack;
  logic             err;
  logic             puf_req;
  logic             puf_valid;
  logic [WIDTH-1:0] puf_data;
  logic             v_clear;
  logic             v_ready;
  logic             v_vote;
  logic [WIDTH-1:0] v_data;
  logic             v_done;
  logic [WIDTH-1:0] v_result;

  modport master (
    input  start, key_ack,
    input  puf_valid, puf_data,
    input  v_done, v_result,
    output busy, key_valid, key_out, err,
    output puf_req,
    output v_clear, v_ready, v_vote, v_data
  );

  modport slave (
    output start, key_ack,
    output puf_valid, puf_data,
    output v_done, v_result,
    input  busy, key_valid, key_out, err,
    input  puf_req,
    input  v_clear, v_ready, v_vote, v_data
  );
endinterface

// File: rtl/puf_vote_sequencer.sv
// Drives NUM_READS PUF evaluations into a majority voter and
// hands the voted key to its consumer over a valid/ack handshake.
module puf_vote_sequencer #(
  parameter int WIDTH          = 128,
  parameter int NUM_READS      = 9,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  puf_vote_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_REQ,
    S_FEED,
    S_GAP,
    S_VOTE,
    S_OUT,
    S_ABORT
  } state_t;

  localparam logic [5:0] RD_LAST =
    6'(NUM_READS);
  localparam logic [7:0] SET_LAST =
    (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TO_LAST =
    16'(TIMEOUT_CYCLES - 1);

  state_t           state_q;
  state_t           state_d;
  logic [5:0]       rd_cnt;
  logic [7:0]       set_cnt;
  logic [15:0]      to_cnt;
  logic [WIDTH-1:0] v_data_q;
  logic [WIDTH-1:0] key_q;
  logic             rd_last;
  logic             to_hit;

  assign rd_last = (rd_cnt + 6'd1) == RD_LAST;
  assign to_hit  = to_cnt == TO_LAST;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (bus.start) state_d = S_CLEAR;
      S_CLEAR:
        state_d = S_REQ;
      S_REQ:
        if (bus.puf_valid) state_d = S_FEED;
        else if (to_hit)   state_d = S_ABORT;
      S_FEED:
        if (rd_last)                 state_d = S_VOTE;
        else if (SETTLE_CYCLES == 0) state_d = S_REQ;
        else                         state_d = S_GAP;
      S_GAP:
        if (set_cnt == SET_LAST) state_d = S_REQ;
      S_VOTE:
        if (bus.v_done)  state_d = S_OUT;
        else if (to_hit) state_d = S_ABORT;
      S_OUT:
        if (bus.key_ack) state_d = S_IDLE;
      S_ABORT:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Settle and timeout counters restart on every state change,
  // so each REQ/VOTE/GAP visit gets its own full budget.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rd_cnt   <= '0;
      set_cnt  <= '0;
      to_cnt   <= '0;
      v_data_q <= '0;
      key_q    <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == S_IDLE)
        rd_cnt <= '0;
      else if (state_q == S_FEED)
        rd_cnt <= rd_cnt + 6'd1;

      if (state_d != state_q)
        set_cnt <= '0;
      else if (state_q == S_GAP)
        set_cnt <= set_cnt + 8'd1;

      if (state_d != state_q)
        to_cnt <= '0;
      else if (state_q == S_REQ || state_q == S_VOTE)
        to_cnt <= to_cnt + 16'd1;

      if (state_q == S_REQ && bus.puf_valid)
        v_data_q <= bus.puf_data;

      if (state_q == S_VOTE && bus.v_done)
        key_q <= bus.v_result;
    end
  end

  assign bus.busy      = state_q != S_IDLE;
  assign bus.puf_req   = state_q == S_REQ;
  assign bus.v_clear   = state_q == S_CLEAR
                      || state_q == S_ABORT;
  assign bus.v_ready   = state_q == S_FEED;
  assign bus.v_vote    = state_q == S_VOTE;
  assign bus.key_valid = state_q == S_OUT;
  assign bus.err       = state_q == S_ABORT;
  assign bus.v_data    = v_data_q;
  assign bus.key_out   = key_q;

endmodule

// File: tb/tb_puf_vote_sequencer.sv
// Directed bench for puf_vote_sequencer with a behavioural
// PUF array and a threshold-5 majority voter around it.
module tb_puf_vote_sequencer;
  localparam int W   = 128;
  localparam int THR = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  puf_vote_sequencer_if #(.WIDTH(W)) bus();

  puf_vote_sequencer #(
    .WIDTH(W),
    .NUM_READS(9),
    .SETTLE_CYCLES(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] tbl [9];
  int puf_lim = 9;
  bit toggle_mode = 1'b1;
  int puf_idx = 0;

  int vcnt [W];
  bit voted = 1'b0;

  int cyc = 0, n_clear = 0, n_ready = 0, n_vote = 0;
  int n_kv = 0, n_err = 0, gap_bad = 0, excl_bad = 0;
  int err_noclr = 0, req_run = 0, err_req_len = 0;
  int prev_ready = -1, clear_cyc = 0, kv_cyc = 0;
  int rdy_in_rst = 0;
  bit kv_prev = 1'b0, vote_prev = 1'b0;
  logic rst_seen = 1'b0;

  always @(posedge clk) rst_seen = rst;

  // Monitor, PUF array and voter all act mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (cyc == 1) begin
      bus.v_done   = 1'b0;
      bus.v_result = '0;
      for (int i = 0; i < W; i++) vcnt[i] = 0;
    end
    if (int'(bus.v_clear) + int'(bus.v_ready)
        + int'(bus.v_vote) > 1)
      excl_bad++;
    if (bus.v_clear === 1'b1) begin
      n_clear++;
      clear_cyc = cyc;
      prev_ready = -1;
    end
    if (bus.v_ready === 1'b1) begin
      n_ready++;
      if (!rst_seen) rdy_in_rst++;
      if (prev_ready >= 0 && cyc - prev_ready != 6)
        gap_bad++;
      prev_ready = cyc;
    end
    if (bus.v_vote === 1'b1 && !vote_prev) n_vote++;
    vote_prev = bus.v_vote === 1'b1;
    if (bus.key_valid === 1'b1 && !kv_prev) begin
      n_kv++;
      kv_cyc = cyc;
    end
    kv_prev = bus.key_valid === 1'b1;
    if (bus.err === 1'b1) begin
      n_err++;
      err_req_len = req_run;
      if (bus.v_clear !== 1'b1) err_noclr++;
    end
    if (bus.puf_req === 1'b1) req_run++;
    else req_run = 0;

    if (!rst_seen || bus.v_clear === 1'b1) puf_idx = 0;
    if (toggle_mode) begin
      bus.puf_valid = (cyc % 2) == 1;
      bus.puf_data  = {4{32'h1234_5678}};
    end else if (bus.puf_req === 1'b1
                 && puf_idx < puf_lim) begin
      bus.puf_valid = 1'b1;
      bus.puf_data  = tbl[puf_idx];
      puf_idx++;
    end else begin
      bus.puf_valid = 1'b0;
    end

    if (bus.v_clear === 1'b1) begin
      for (int i = 0; i < W; i++) vcnt[i] = 0;
      bus.v_done = 1'b0;
      voted = 1'b0;
    end
    if (bus.v_ready === 1'b1)
      for (int i = 0; i < W; i++)
        vcnt[i] += int'(bus.v_data[i]);
    if (voted && bus.v_done !== 1'b1) begin
      bus.v_done = 1'b1;
      for (int i = 0; i < W; i++)
        bus.v_result[i] = vcnt[i] >= THR;
    end
    voted = bus.v_vote === 1'b1;
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic run_start();
    sync();
    bus.start = 1'b1;
    sync();
    bus.start = 1'b0;
  endtask

  task automatic wait_kv(input string tag);
    int n = 0;
    while (bus.key_valid !== 1'b1 && n < 400) begin
      sync();
      n++;
    end
    check(tag, W'(bus.key_valid), W'(1));
    @(negedge clk);
    #1;
  endtask

  task automatic ack_key();
    sync();
    bus.key_ack = 1'b1;
    sync();
    bus.key_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, r0, v0, g0, k0, e0, ec0, n, bad;
    logic [W-1:0] exp_key;

    bus.start   = 1'b0;
    bus.key_ack = 1'b0;

    // 1: reset with puf_valid toggling
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", W'(bus.busy), W'(0));
    check("rst_kv", W'(bus.key_valid), W'(0));
    check("rst_err", W'(bus.err), W'(0));
    check("rst_req", W'(bus.puf_req), W'(0));
    check("rst_vsig",
          W'({bus.v_clear, bus.v_ready, bus.v_vote}),
          W'(0));
    check("rst_key", bus.key_out, W'(0));
    check("rst_vdata", bus.v_data, W'(0));
    sync();
    rst = 1'b1;
    toggle_mode = 1'b0;
    repeat (3) sync();
    check("rst_idle", W'(bus.busy), W'(0));

    // 2: nominal run, all reads identical
    exp_key = {16{8'hA5}};
    for (int i = 0; i < 9; i++) tbl[i] = exp_key;
    puf_lim = 9;
    c0 = n_clear; r0 = n_ready;
    v0 = n_vote; g0 = gap_bad;
    run_start();
    wait_kv("nom_kv");
    check("nom_key", bus.key_out, exp_key);
    check("nom_clr", W'(n_clear - c0), W'(1));
    check("nom_rdy", W'(n_ready - r0), W'(9));
    check("nom_vote", W'(n_vote - v0), W'(1));
    check("nom_gap", W'(gap_bad - g0), W'(0));
    check("nom_lat", W'(kv_cyc - clear_cyc), W'(53));
    repeat (3) sync();
    check("nom_hold", W'(bus.key_valid), W'(1));
    ack_key();
    check("nom_kv_off", W'(bus.key_valid), W'(0));
    check("nom_busy", W'(bus.busy), W'(0));
    check("nom_keep", bus.key_out, exp_key);

    // 3: noisy majority 5 vs 4
    for (int i = 0; i < 9; i++)
      tbl[i] = (i % 2 == 0) ? {8{16'hFF00}}
                            : {8{16'h00FF}};
    run_start();
    wait_kv("noisy_kv");
    check("noisy_key", bus.key_out, {8{16'hFF00}});
    ack_key();

    // 4: PUF stops answering after 3 reads
    for (int i = 0; i < 9; i++) tbl[i] = {16{8'hA5}};
    puf_lim = 3;
    k0 = n_kv; e0 = n_err;
    ec0 = err_noclr; r0 = n_ready;
    run_start();
    n = 0;
    while (bus.err !== 1'b1 && n < 200) begin
      sync();
      n++;
    end
    check("to_err", W'(bus.err), W'(1));
    check("to_vclr", W'(bus.v_clear), W'(1));
    @(negedge clk);
    #1;
    check("to_len", W'(err_req_len), W'(16));
    check("to_noclr", W'(err_noclr - ec0), W'(0));
    check("to_nerr", W'(n_err - e0), W'(1));
    check("to_rdy", W'(n_ready - r0), W'(3));
    sync();
    check("to_pulse", W'(bus.err), W'(0));
    check("to_busy", W'(bus.busy), W'(0));
    check("to_nokv", W'(n_kv - k0), W'(0));
    puf_lim = 9;

    // 5: start held high, slow ack
    exp_key = {4{32'hDEAD_BEEF}};
    for (int i = 0; i < 9; i++) tbl[i] = exp_key;
    c0 = n_clear;
    sync();
    bus.start = 1'b1;
    wait_kv("edge_kv");
    bad = 0;
    repeat (20) begin
      sync();
      if (bus.key_out !== exp_key
          || bus.key_valid !== 1'b1)
        bad++;
    end
    check("edge_stable", W'(bad), W'(0));
    check("edge_key", bus.key_out, exp_key);
    bus.start = 1'b0;
    bus.key_ack = 1'b1;
    sync();
    bus.key_ack = 1'b0;
    repeat (3) sync();
    check("edge_idle", W'(bus.busy), W'(0));
    check("edge_one", W'(n_clear - c0), W'(1));

    // 6: reset after 5 reads, then a fresh run
    for (int i = 0; i < 9; i++) tbl[i] = {16{8'h5A}};
    r0 = n_ready;
    run_start();
    n = 0;
    while (n_ready - r0 < 5 && n < 200) begin
      sync();
      n++;
    end
    check("mid_reads", W'(n_ready - r0), W'(5));
    rst = 1'b0;
    sync();
    rst = 1'b1;
    check("mid_busy", W'(bus.busy), W'(0));
    check("mid_vdata", bus.v_data, W'(0));
    r0 = n_ready;
    repeat (3) sync();
    check("mid_quiet", W'(n_ready - r0), W'(0));
    exp_key = {16{8'h3C}};
    for (int i = 0; i < 9; i++) tbl[i] = exp_key;
    c0 = n_clear; g0 = gap_bad;
    run_start();
    wait_kv("mid_kv");
    check("mid_clr", W'(n_clear - c0), W'(1));
    check("mid_rdy", W'(n_ready - r0), W'(9));
    check("mid_gap", W'(gap_bad - g0), W'(0));
    check("mid_key", bus.key_out, exp_key);
    ack_key();

    check("excl", W'(excl_bad), W'(0));
    check("rdy_in_rst", W'(rdy_in_rst), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
